// File: rtl/regfile_multiport.sv
// Multiported integer register file with write-to-read bypass and a per-register busy scoreboard.
// Optional registered debug tap: define REGFILE_DEBUG_TAP_EN to add dbg_addr/dbg_data.
module regfile_multiport #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_READ = 2,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_READ*AW-1:0]   rd_addr,
    output logic [NUM_READ*XLEN-1:0] rd_data,
    output logic [NUM_READ-1:0]      rd_busy,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [XLEN-1:0]          wr_data,
    input  logic                     alloc_en,
    input  logic [AW-1:0]            alloc_addr,
    output logic                     busy_any
`ifdef REGFILE_DEBUG_TAP_EN
    ,
    input  logic [AW-1:0]            dbg_addr,
    output logic [XLEN-1:0]          dbg_data
`endif
);

    logic [XLEN-1:0]     regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic                write_hit;

    assign write_hit = wr_en && (wr_addr != '0);

    // Set is applied after clear so a same-edge alloc wins over writeback.
    always_comb begin
        busy_next = busy;
        if (wr_en) begin
            busy_next[wr_addr] = 1'b0;
        end
        if (alloc_en && (alloc_addr != '0)) begin
            busy_next[alloc_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (write_hit) begin
                regs[wr_addr] <= wr_data;
            end
            busy <= busy_next;
        end
    end

    // Bypass is gated by reset_n so every read returns zero while reset is held.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned k = 0; k < NUM_READ; k++) begin
            rd_data[k*XLEN +: XLEN] = regs[rd_addr[k*AW +: AW]];
            rd_busy[k]              = busy[rd_addr[k*AW +: AW]];
            if ((BYPASS != 0) && reset_n && write_hit && (rd_addr[k*AW +: AW] == wr_addr)) begin
                rd_data[k*XLEN +: XLEN] = wr_data;
                rd_busy[k]              = 1'b0;
            end
        end
    end

    assign busy_any = |busy;

`ifdef REGFILE_DEBUG_TAP_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dbg_data <= '0;
        end else if (write_hit && (wr_addr == dbg_addr)) begin
            dbg_data <= wr_data;
        end else begin
            dbg_data <= regs[dbg_addr];
        end
    end
`endif

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport: one BYPASS=1 and one BYPASS=0 instance share stimulus.
module tb_regfile_multiport;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clock = 1'b0;
    logic            reset_n;
    logic [2*AW-1:0] rd_addr;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;
    logic            alloc_en;
    logic [AW-1:0]   alloc_addr;

    logic [2*XLEN-1:0] rd_data, rd_data_nb;
    logic [1:0]        rd_busy, rd_busy_nb;
    logic              busy_any, busy_any_nb;
`ifdef REGFILE_DEBUG_TAP_EN
    logic [AW-1:0]   dbg_addr;
    logic [XLEN-1:0] dbg_data, dbg_data_nb;
`endif

    regfile_multiport #(.XLEN(XLEN), .NUM_REGS(32), .NUM_READ(2), .BYPASS(1)) dut (
        .clock(clock), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy_any(busy_any)
`ifdef REGFILE_DEBUG_TAP_EN
        , .dbg_addr(dbg_addr), .dbg_data(dbg_data)
`endif
    );

    regfile_multiport #(.XLEN(XLEN), .NUM_REGS(32), .NUM_READ(2), .BYPASS(0)) dut_nb (
        .clock(clock), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data_nb),
        .rd_busy(rd_busy_nb), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy_any(busy_any_nb)
`ifdef REGFILE_DEBUG_TAP_EN
        , .dbg_addr(dbg_addr), .dbg_data(dbg_data_nb)
`endif
    );

    always #5 clock = ~clock;

    typedef enum int {
        OBS_DATA0, OBS_DATA1, OBS_BUSY0, OBS_BUSY1, OBS_BUSY_ANY,
        OBS_NB_DATA1, OBS_NB_BUSY1, OBS_DBG
    } obs_e;

    typedef struct {
        string       tag;
        obs_e        sel;
        logic [31:0] exp;
    } exp_t;

    exp_t expq[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input obs_e sel);
        case (sel)
            OBS_DATA0:    return rd_data[31:0];
            OBS_DATA1:    return rd_data[63:32];
            OBS_BUSY0:    return {31'b0, rd_busy[0]};
            OBS_BUSY1:    return {31'b0, rd_busy[1]};
            OBS_BUSY_ANY: return {31'b0, busy_any};
            OBS_NB_DATA1: return rd_data_nb[63:32];
            OBS_NB_BUSY1: return {31'b0, rd_busy_nb[1]};
`ifdef REGFILE_DEBUG_TAP_EN
            OBS_DBG:      return dbg_data;
`endif
            default:      return 'x;
        endcase
    endfunction

    task automatic expect_val(input string tag, input obs_e sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        expq.push_back(e);
    endtask

    // Let combinational outputs settle, then compare every queued expectation.
    task automatic drain();
        exp_t e;
        #1;
        while (expq.size() > 0) begin
            e = expq.pop_front();
            check(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        wr_en    = 1'b0;
        alloc_en = 1'b0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
    endtask

    task automatic do_alloc(input logic [AW-1:0] a);
        alloc_en   = 1'b1;
        alloc_addr = a;
    endtask

    initial begin
        reset_n    = 1'b0;
        rd_addr    = '0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        alloc_en   = 1'b0;
        alloc_addr = '0;
`ifdef REGFILE_DEBUG_TAP_EN
        dbg_addr   = '0;
`endif
        set_rd(5'd5, 5'd0);
        expect_val("reset_r5", OBS_DATA0, 32'h0);
        expect_val("reset_r0", OBS_DATA1, 32'h0);
        expect_val("reset_busy_any", OBS_BUSY_ANY, 32'h0);
        drain();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        step();

        // Populate r5 and claim r6 so reset has something to clear.
        do_write(5'd5, 32'h1111_1111);
        do_alloc(5'd6);
        step();
        idle();
        set_rd(5'd5, 5'd6);
        expect_val("pre_reset_r5", OBS_DATA0, 32'h1111_1111);
        expect_val("pre_reset_busy_r6", OBS_BUSY1, 32'h1);
        expect_val("pre_reset_busy_any", OBS_BUSY_ANY, 32'h1);
        drain();

        // Mid-cycle reset pulse with a pending write and allocation.
        do_write(5'd5, 32'hDEAD_BEEF);
        do_alloc(5'd8);
        #2;
        reset_n = 1'b0;
        expect_val("in_reset_r5", OBS_DATA0, 32'h0);
        expect_val("in_reset_busy_any", OBS_BUSY_ANY, 32'h0);
        drain();
        step();
        idle();
        @(negedge clock);
        reset_n = 1'b1;
        step();
        set_rd(5'd5, 5'd8);
        expect_val("post_reset_r5", OBS_DATA0, 32'h0);
        expect_val("post_reset_busy_r8", OBS_BUSY1, 32'h0);
        expect_val("post_reset_busy_any", OBS_BUSY_ANY, 32'h0);
        drain();

        do_write(5'd7, 32'h1234_5678);
        step();
        idle();
        set_rd(5'd7, 5'd7);
        expect_val("r7_port0", OBS_DATA0, 32'h1234_5678);
        expect_val("r7_port1", OBS_DATA1, 32'h1234_5678);
        expect_val("r7_busy0", OBS_BUSY0, 32'h0);
        drain();

        do_write(5'd0, 32'hFFFF_FFFF);
        do_alloc(5'd0);
        set_rd(5'd0, 5'd7);
        expect_val("r0_bypass_zero", OBS_DATA0, 32'h0);
        drain();
        step();
        idle();
        expect_val("r0_stored_zero", OBS_DATA0, 32'h0);
        expect_val("r0_not_busy", OBS_BUSY0, 32'h0);
        expect_val("r0_alloc_ignored", OBS_BUSY_ANY, 32'h0);
        drain();

        // Bypass: r3 holds a prior value and is busy when its writeback arrives.
        do_write(5'd3, 32'h0BAD_0003);
        step();
        idle();
        do_alloc(5'd3);
        step();
        idle();
        do_write(5'd3, 32'hA5A5_A5A5);
        set_rd(5'd0, 5'd3);
        expect_val("bypass_data", OBS_DATA1, 32'hA5A5_A5A5);
        expect_val("bypass_busy", OBS_BUSY1, 32'h0);
        expect_val("bypass_busy_any_stored", OBS_BUSY_ANY, 32'h1);
        expect_val("nobypass_data", OBS_NB_DATA1, 32'h0BAD_0003);
        expect_val("nobypass_busy", OBS_NB_BUSY1, 32'h1);
        drain();
        step();
        idle();
        expect_val("r3_after_write", OBS_DATA1, 32'hA5A5_A5A5);
        expect_val("r3_after_write_nb", OBS_NB_DATA1, 32'hA5A5_A5A5);
        expect_val("r3_busy_cleared", OBS_BUSY_ANY, 32'h0);
        drain();

        do_alloc(5'd9);
        step();
        idle();
        set_rd(5'd9, 5'd0);
        expect_val("r9_busy", OBS_BUSY0, 32'h1);
        expect_val("r9_busy_any", OBS_BUSY_ANY, 32'h1);
        drain();
        do_write(5'd9, 32'h42);
        step();
        idle();
        expect_val("r9_data", OBS_DATA0, 32'h42);
        expect_val("r9_not_busy", OBS_BUSY0, 32'h0);
        expect_val("r9_busy_any_clear", OBS_BUSY_ANY, 32'h0);
        drain();

        // Same-edge alloc and writeback on r4, plus an independent alloc of r10.
        do_write(5'd4, 32'h77);
        do_alloc(5'd4);
        step();
        idle();
        set_rd(5'd4, 5'd10);
        expect_val("collide_r4_data", OBS_DATA0, 32'h77);
        expect_val("collide_r4_busy", OBS_BUSY0, 32'h1);
        drain();
        do_write(5'd4, 32'h78);
        do_alloc(5'd10);
        step();
        idle();
        expect_val("r4_released_data", OBS_DATA0, 32'h78);
        expect_val("r4_released_busy", OBS_BUSY0, 32'h0);
        expect_val("r10_busy", OBS_BUSY1, 32'h1);
        drain();
        do_write(5'd10, 32'h10);
        do_alloc(5'd10);
        step();
        idle();
        expect_val("r10_realloc_busy", OBS_BUSY1, 32'h1);
        drain();
        do_write(5'd10, 32'h11);
        step();
        idle();
        expect_val("r10_final_busy", OBS_BUSY1, 32'h0);
        expect_val("r10_final_data", OBS_DATA1, 32'h11);
        drain();

`ifdef REGFILE_DEBUG_TAP_EN
        dbg_addr = 5'd1;
        step();
        expect_val("dbg_before_write", OBS_DBG, 32'h0);
        drain();
        do_write(5'd1, 32'h55);
        step();
        idle();
        step();
        expect_val("dbg_after_write", OBS_DBG, 32'h55);
        drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
